// File: rtl/mux_rr_nx1_param.sv
// N_CH-to-1 registered multiplexer with per-channel valid/pop handshake.
// Manual mode routes the channel named by selector. Round-robin mode scans
// from a rotating pointer and skips idle channels.
// Optional feature macro: MUX_RR_EN. When it is defined, the round-robin
// arbiter and its pointer register are built. When it is undefined, mode is
// ignored and the block always behaves as in manual mode.
module mux_rr_nx1_param #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N_CH  = 4,
  parameter int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic                  clok,
  input  logic                  reset_L,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      selector,
  input  logic                  pause,
  input  logic [N_CH-1:0]       valid_in,
  input  logic [N_CH*WIDTH-1:0] bus_in,
  output logic [N_CH-1:0]       pop,
  output logic [WIDTH-1:0]      data_out,
  output logic                  valid_out,
  output logic [SEL_W-1:0]      grant_id
);

  // Channel chosen this cycle and whether it actually has data.
  logic [SEL_W-1:0] cand;
  logic             cand_valid;
  // Transfer ignoring reset; the flops only see this while reset is released.
  logic             xfer_core;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] grant_q, grant_d;

`ifdef MUX_RR_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] scan_idx;
  logic             rr_found;

  // First valid channel at or after ptr, wrapping modulo N_CH.
  // N_CH is a power of two, so SEL_W-bit addition wraps naturally.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    scan_idx = ptr_q;
    for (int unsigned k = 0; k < N_CH; k++) begin
      scan_idx = ptr_q + SEL_W'(k);
      if (!rr_found && valid_in[scan_idx]) begin
        rr_found = 1'b1;
        rr_idx   = scan_idx;
      end
    end
  end

  // Mode change acts in the same cycle; it never touches the pointer.
  always_comb begin
    cand       = selector;
    cand_valid = valid_in[selector];
    if (mode) begin
      cand       = rr_idx;
      cand_valid = rr_found;
    end
  end

  // Pointer moves past the granted channel only on a round-robin transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (mode && xfer_core) begin
      ptr_d = cand + SEL_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clok or negedge reset_L) begin
    if (!reset_L) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Without the arbiter, mode has no effect.
  logic unused_mode;
  assign unused_mode = mode;

  // Manual routing only.
  always_comb begin
    cand       = selector;
    cand_valid = valid_in[selector];
  end
`endif

  assign xfer_core = cand_valid & ~pause;
  // Reset gates pop so that a word is never acknowledged while in reset.
  assign xfer      = xfer_core & reset_L;

  // Data word of the candidate channel.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (cand == SEL_W'(i)) begin
        sel_data = bus_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot acknowledge to the granted source, same cycle as capture.
  always_comb begin
    pop = '0;
    if (xfer) begin
      pop[cand] = 1'b1;
    end
  end

  // Next output state: pause freezes everything, an idle cycle clears valid.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    grant_d = grant_q;
    if (!pause) begin
      valid_d = cand_valid;
      if (cand_valid) begin
        data_d  = sel_data;
        grant_d = cand;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clok or negedge reset_L) begin
    if (!reset_L) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_mux_rr_nx1_param.sv
// Self-checking bench for mux_rr_nx1_param (WIDTH=4, N_CH=4).
// Reference model follows MUX_RR_EN: with it undefined, mode is ignored.
module tb_mux_rr_nx1_param;

  localparam int WIDTH = 4;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;
`ifdef MUX_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                  clok;
  logic                  reset_L;
  logic                  mode;
  logic [SEL_W-1:0]      selector;
  logic                  pause;
  logic [N_CH-1:0]       valid_in;
  logic [N_CH*WIDTH-1:0] bus_in;
  logic [N_CH-1:0]       pop;
  logic [WIDTH-1:0]      data_out;
  logic                  valid_out;
  logic [SEL_W-1:0]      grant_id;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic [SEL_W-1:0] m_grant;
  int               m_ptr;

  mux_rr_nx1_param #(
    .WIDTH(WIDTH),
    .N_CH (N_CH)
  ) dut (
    .clok     (clok),
    .reset_L  (reset_L),
    .mode     (mode),
    .selector (selector),
    .pause    (pause),
    .valid_in (valid_in),
    .bus_in   (bus_in),
    .pop      (pop),
    .data_out (data_out),
    .valid_out(valid_out),
    .grant_id (grant_id)
  );

  initial clok = 1'b0;
  always #5 clok = ~clok;

  task automatic model_reset();
    m_data  = '0;
    m_valid = 1'b0;
    m_grant = '0;
    m_ptr   = 0;
  endtask

  // Channel the rules pick this cycle, and whether it holds data.
  task automatic model_pick(output int c, output bit ok);
    c  = 0;
    ok = 1'b0;
    if (RR && mode) begin
      for (int k = 0; k < N_CH; k++) begin
        if (!ok && valid_in[(m_ptr + k) % N_CH]) begin
          c  = (m_ptr + k) % N_CH;
          ok = 1'b1;
        end
      end
    end else begin
      c  = int'(selector);
      ok = valid_in[selector];
    end
  endtask

  task automatic model_pop(output logic [N_CH-1:0] ep);
    int c;
    bit ok;
    model_pick(c, ok);
    ep = (ok && !pause && reset_L) ? N_CH'(1 << c) : '0;
  endtask

  // Model the clock edge from the current inputs, then move to the next falling edge.
  task automatic tick();
    int c;
    bit ok;
    model_pick(c, ok);
    if (reset_L && !pause) begin
      if (ok) begin
        m_data  = bus_in[c*WIDTH +: WIDTH];
        m_valid = 1'b1;
        m_grant = SEL_W'(c);
        if (RR && mode) m_ptr = (c + 1) % N_CH;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clok);
    @(negedge clok);
  endtask

  task automatic test_reset();
    logic [N_CH-1:0] ep;
    reset_L  = 1'b0;
    mode     = 1'b0;
    selector = '0;
    pause    = 1'b0;
    valid_in = 4'hF;
    bus_in   = 16'($urandom);
    #1;
    model_reset();
    total++;
    if ({pop, valid_out, grant_id, data_out} !== 11'b0) begin
      bad++;
      $display("FAIL reset_idle got pop=%b v=%b g=%0d d=%h want all zero",
               pop, valid_out, grant_id, data_out);
    end
    @(negedge clok);
    reset_L = 1'b1;
    #1;
    tick();
    total++;
    if (valid_out !== 1'b1 || data_out !== m_data) begin
      bad++;
      $display("FAIL reset_prep got v=%b d=%h want v=1 d=%h", valid_out, data_out, m_data);
    end
    // Assert reset mid-cycle with a transfer pending on the inputs.
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    model_pop(ep);
    total++;
    if ({pop, valid_out, grant_id, data_out} !== {ep, 7'b0}) begin
      bad++;
      $display("FAIL reset_async got pop=%b v=%b g=%0d d=%h want all zero",
               pop, valid_out, grant_id, data_out);
    end
    @(negedge clok);
    reset_L = 1'b1;
  endtask

  task automatic test_manual_sweep();
    logic [N_CH-1:0] ep;
    mode     = 1'b0;
    pause    = 1'b0;
    valid_in = 4'hF;
    bus_in   = 16'($urandom);
    for (int i = 0; i < N_CH; i++) begin
      selector = SEL_W'(i);
      #1;
      model_pop(ep);
      total++;
      if (pop !== ep || pop !== 4'(1 << i)) begin
        bad++;
        $display("FAIL sweep_pop i=%0d got=%b want=%b", i, pop, ep);
      end
      tick();
      total++;
      if (valid_out !== 1'b1 || grant_id !== SEL_W'(i) ||
          data_out !== bus_in[i*WIDTH +: WIDTH]) begin
        bad++;
        $display("FAIL sweep_out i=%0d got v=%b g=%0d d=%h want v=1 g=%0d d=%h",
                 i, valid_out, grant_id, data_out, i, bus_in[i*WIDTH +: WIDTH]);
      end
    end
  endtask

  task automatic test_manual_invalid();
    logic [WIDTH-1:0] prior;
    prior    = data_out;
    mode     = 1'b0;
    pause    = 1'b0;
    selector = 2'd2;
    valid_in = 4'b1011;
    bus_in   = 16'($urandom);
    #1;
    total++;
    if (pop !== 4'b0000) begin
      bad++;
      $display("FAIL invalid_pop got=%b want=0000", pop);
    end
    tick();
    total++;
    if (valid_out !== 1'b0 || data_out !== prior || data_out !== m_data) begin
      bad++;
      $display("FAIL invalid_out got v=%b d=%h want v=0 d=%h", valid_out, data_out, prior);
    end
  endtask

  task automatic test_rr_fair();
    logic [N_CH-1:0] ep;
    mode     = 1'b1;
    pause    = 1'b0;
    selector = '0;
    for (int i = 0; i < 9; i++) begin
      valid_in = (i < 5) ? 4'b1111 : 4'b1010;
      bus_in   = 16'($urandom);
      #1;
      model_pop(ep);
      total++;
      if (pop !== ep) begin
        bad++;
        $display("FAIL rr_pop i=%0d got=%b want=%b", i, pop, ep);
      end
      tick();
      total++;
      if ({valid_out, grant_id, data_out} !== {m_valid, m_grant, m_data}) begin
        bad++;
        $display("FAIL rr_out i=%0d got v=%b g=%0d d=%h want v=%b g=%0d d=%h",
                 i, valid_out, grant_id, data_out, m_valid, m_grant, m_data);
      end
    end
  endtask

  task automatic test_pause();
    logic [N_CH-1:0] ep;
    mode     = 1'b1;
    valid_in = 4'hF;
    for (int i = 0; i < 8; i++) begin
      pause  = (i >= 2 && i < 5);
      bus_in = 16'($urandom);
      #1;
      model_pop(ep);
      total++;
      if (pop !== ep) begin
        bad++;
        $display("FAIL pause_pop i=%0d got=%b want=%b", i, pop, ep);
      end
      tick();
      total++;
      if ({valid_out, grant_id, data_out} !== {m_valid, m_grant, m_data}) begin
        bad++;
        $display("FAIL pause_out i=%0d got v=%b g=%0d d=%h want v=%b g=%0d d=%h",
                 i, valid_out, grant_id, data_out, m_valid, m_grant, m_data);
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_random();
    logic [N_CH-1:0] ep;
    for (int i = 0; i < 300; i++) begin
      mode     = 1'($urandom_range(0, 1));
      selector = SEL_W'($urandom_range(0, N_CH - 1));
      pause    = ($urandom_range(0, 3) == 0);
      valid_in = N_CH'($urandom_range(0, 15));
      bus_in   = 16'($urandom);
      #1;
      model_pop(ep);
      total++;
      if (pop !== ep) begin
        bad++;
        $display("FAIL rand_pop i=%0d got=%b want=%b", i, pop, ep);
      end
      tick();
      total++;
      if ({valid_out, grant_id, data_out} !== {m_valid, m_grant, m_data}) begin
        bad++;
        $display("FAIL rand_out i=%0d got v=%b g=%0d d=%h want v=%b g=%0d d=%h",
                 i, valid_out, grant_id, data_out, m_valid, m_grant, m_data);
      end
    end
    pause = 1'b0;
  endtask

  initial begin
    reset_L  = 1'b0;
    mode     = 1'b0;
    selector = '0;
    pause    = 1'b0;
    valid_in = '0;
    bus_in   = '0;
    model_reset();
    @(negedge clok);
    test_reset();
    test_manual_sweep();
    test_manual_invalid();
    test_rr_fair();
    test_pause();
    test_random();
    test_reset();
    test_rr_fair();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
